uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares a single uart_tx instance between c_nreq independent requesters. Each requester offers one c_dwidth-bit word with a valid/ready handshake. The arbiter grants one requester, drives uart_tx din_i/tx_start_i, and waits for tx_done_tick_o. It then enforces an inter-frame guard time before the next grant. It sits between the system-side producers and uart_tx.

---
 rtl/uart_arb_pkg.sv | 37 +++
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - state encoding, frame length and width helpers for the uart_tx arbiter
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

  // Bits needed to index 'value' distinct items; never less than 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Clocks occupied by one uart_tx frame: start bit, data bits, stop bits.
  function automatic int frame_clocks(input int clkfreq, input int baudrate,
                                      input int dwidth, input int stopbit);
    return (clkfreq / baudrate) * (dwidth + 1 + stopbit);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshake and uart_tx side signals of the arbiter
interface uart_tx_arbiter_if #(
  parameter int c_nreq   = 4,
  parameter int c_dwidth = 10
);
  logic [c_nreq-1:0]          req_valid_i;
  logic [c_nreq*c_dwidth-1:0] req_data_i;
  logic [c_nreq-1:0]          req_ready_o;
  logic [c_dwidth-1:0]        tx_din_o;
  logic                       tx_start_o;
  logic                       tx_done_tick_i;
  logic [c_nreq-1:0]          grant_o;
  logic                       busy_o;
  logic                       timeout_o;

  modport slave (
    input  req_valid_i, req_data_i, tx_done_tick_i,
    output req_ready_o, tx_din_o, tx_start_o, grant_o, busy_o, timeout_o
  );

  modport master (
    output req_valid_i, req_data_i, tx_done_tick_i,
    input  req_ready_o, tx_din_o, tx_start_o, grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker: first valid index at or after ptr, wrapping
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int c_nreq = 4,
  localparam int c_ptrw = clog2(c_nreq)
) (
  input  logic [c_nreq-1:0] req_i,
  input  logic [c_ptrw-1:0] ptr_i,
  output logic [c_nreq-1:0] grant_o,
  output logic              any_o
);

  logic [c_ptrw-1:0] idx;
  logic              found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < c_nreq; i++) begin
      idx = c_ptrw'((int'(ptr_i) + i) % c_nreq);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharer of one uart_tx; define UART_ARB_TIMEOUT_EN to abort stuck frames
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int c_nreq     = 4,
  parameter int c_dwidth   = 10,
  parameter int c_clkfreq  = 100_000_000,
  parameter int c_baudrate = 10_000_000,
  parameter int c_stopbit  = 2,
  parameter int c_guard    = 4,
  parameter int c_timeout  = 260
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);

  localparam int c_frame = frame_clocks(c_clkfreq, c_baudrate, c_dwidth, c_stopbit);
  localparam int c_ptrw  = clog2(c_nreq);
  localparam int c_cntw  = clog2(max3(c_frame, c_guard, c_timeout) + 1);

  state_t              state_q, state_d;
  logic [c_cntw-1:0]   cnt_q, cnt_d;
  logic [c_ptrw-1:0]   ptr_q, ptr_d;
  logic [c_nreq-1:0]   grant_q, grant_d;
  logic [c_nreq-1:0]   ready_q, ready_d;
  logic [c_dwidth-1:0] din_q, din_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
`ifdef UART_ARB_TIMEOUT_EN
  logic                timeout_q, timeout_d;
`endif

  logic [c_nreq-1:0]   pick_grant;
  logic                pick_any;
  logic [c_ptrw-1:0]   pick_idx;
  logic [c_dwidth-1:0] pick_data;

  uart_rr_pick #(.c_nreq(c_nreq)) u_pick (
    .req_i   (bus.req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int i = 0; i < c_nreq; i++) begin
      if (pick_grant[i]) begin
        pick_idx  = c_ptrw'(i);
        pick_data = bus.req_data_i[i*c_dwidth +: c_dwidth];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    din_d   = din_q;
    start_d = 1'b0;
    ready_d = '0;
`ifdef UART_ARB_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      // uart_tx has no reset, so wait out any frame that may still be on the line
      ST_FLUSH: begin
        if (cnt_q == c_cntw'(c_frame - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cntw'(1);
        end
      end
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_START;
          grant_d = pick_grant;
          ready_d = pick_grant;
          start_d = 1'b1;
          din_d   = pick_data;
          cnt_d   = '0;
          ptr_d   = (int'(pick_idx) == c_nreq - 1) ? '0 : pick_idx + c_ptrw'(1);
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = cnt_q + c_cntw'(1);
      end
      ST_WAIT: begin
        if (bus.tx_done_tick_i) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = (c_guard == 0) ? ST_IDLE : ST_GUARD;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // counter started at START, so the abort pulse lands c_timeout clocks after it
        else if (cnt_q == c_cntw'(c_timeout - 1)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          cnt_d     = '0;
          state_d   = ST_FLUSH;
        end else begin
          cnt_d = cnt_q + c_cntw'(1);
        end
`endif
      end
      ST_GUARD: begin
        if (cnt_q == c_cntw'(c_guard - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cntw'(1);
        end
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FLUSH;
      cnt_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      ready_q   <= '0;
      din_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      din_q     <= din_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.tx_din_o    = din_q;
  assign bus.tx_start_o  = start_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout_o   = timeout_q;
`else
  assign bus.timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 10;
  localparam int FRAME = 130;
  localparam int GUARD = 4;
  localparam int TMO   = 260;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   k;
  int   bad;

  logic [DW-1:0]   wdata [NREQ];
  int              order [6];
  logic [NREQ-1:0] exp_g;

  uart_tx_arbiter_if #(.c_nreq(NREQ), .c_dwidth(DW)) bus ();

  uart_tx_arbiter #(
    .c_nreq(NREQ), .c_dwidth(DW), .c_clkfreq(100_000_000), .c_baudrate(10_000_000),
    .c_stopbit(2), .c_guard(GUARD), .c_timeout(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.tx_start_o !== 1'b1 && cnt < 2000);
    if (bus.tx_start_o !== 1'b1) chk(tag, bus.tx_start_o, 1'b1);
  endtask

  task automatic done_pulse();
    bus.tx_done_tick_i = 1'b1;
    @(negedge clk);
    bus.tx_done_tick_i = 1'b0;
  endtask

  initial begin
    bus.req_valid_i    = '0;
    bus.req_data_i     = '0;
    bus.tx_done_tick_i = 1'b0;
    order = '{0, 1, 3, 0, 1, 3};

    // reset state and flush after release
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_start", bus.tx_start_o, 1'b0);
    chk("rst_grant", bus.grant_o, 4'b0000);
    chk("rst_ready", bus.req_ready_o, 4'b0000);
    chk("rst_din", bus.tx_din_o, 10'h000);
    chk("rst_timeout", bus.timeout_o, 1'b0);
    rst = 1'b0;
    bad = 0;
    repeat (FRAME - 1) begin
      @(negedge clk);
      if (bus.busy_o !== 1'b1 || bus.tx_start_o !== 1'b0) bad++;
    end
    chk("flush_busy_no_start", bad, 0);
    @(negedge clk);
    chk("flush_end_idle", bus.busy_o, 1'b0);

    // single request from requester 2
    bus.req_valid_i = 4'b0100;
    bus.req_data_i[2*DW +: DW] = 10'b1100110011;
    @(negedge clk);
    chk("single_ready", bus.req_ready_o, 4'b0100);
    chk("single_start", bus.tx_start_o, 1'b1);
    chk("single_din", bus.tx_din_o, 10'b1100110011);
    chk("single_grant", bus.grant_o, 4'b0100);
    chk("single_busy", bus.busy_o, 1'b1);
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("single_start_pulse", bus.tx_start_o, 1'b0);
    chk("single_ready_pulse", bus.req_ready_o, 4'b0000);
    repeat (FRAME - 2) @(negedge clk);
    chk("single_din_hold", bus.tx_din_o, 10'b1100110011);
    chk("single_grant_hold", bus.grant_o, 4'b0100);
    done_pulse();
    chk("single_grant_clear", bus.grant_o, 4'b0000);
    bus.req_valid_i = 4'b0100;
    bus.req_data_i[2*DW +: DW] = 10'h0AA;
    wait_start("single2_start", k);
    chk("single_guard_gap", k, GUARD + 1);
    chk("single2_din", bus.tx_din_o, 10'h0AA);
    bus.req_valid_i = '0;
    repeat (FRAME - 1) @(negedge clk);
    done_pulse();

    // contention from reset: requesters 0, 1, 3 held valid
    rst = 1'b1;
    wdata[0] = 10'h201;
    wdata[1] = 10'h102;
    wdata[2] = 10'h000;
    wdata[3] = 10'h3C3;
    for (int i = 0; i < NREQ; i++) bus.req_data_i[i*DW +: DW] = wdata[i];
    bus.req_valid_i = 4'b1011;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_start("cont_start", k);
      chk("cont_gap", k, (i == 0) ? FRAME + 1 : GUARD + 1);
      exp_g = 4'(1 << order[i]);
      chk("cont_grant", bus.grant_o, exp_g);
      chk("cont_ready", bus.req_ready_o, exp_g);
      chk("cont_din", bus.tx_din_o, wdata[order[i]]);
      repeat (FRAME - 1) @(negedge clk);
      done_pulse();
    end

    // pointer wrap: last grant went to 3, now 0 and 3 compete
    bus.req_valid_i = 4'b1001;
    wait_start("wrap_start", k);
    chk("wrap_first", bus.grant_o, 4'b0001);
    repeat (FRAME - 1) @(negedge clk);
    done_pulse();
    wait_start("wrap_start2", k);
    chk("wrap_second", bus.grant_o, 4'b1000);
    repeat (FRAME - 1) @(negedge clk);
    done_pulse();

    // reset 50 clocks into WAIT
    bus.req_valid_i = 4'b0010;
    wait_start("mid_start", k);
    chk("mid_grant", bus.grant_o, 4'b0010);
    bus.req_valid_i = '0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", bus.grant_o, 4'b0000);
    chk("mid_rst_busy", bus.busy_o, 1'b0);
    chk("mid_rst_ready", bus.req_ready_o, 4'b0000);
    chk("mid_rst_din", bus.tx_din_o, 10'h000);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid_i = 4'b0010;
    wait_start("mid_restart", k);
    chk("mid_flush_len", k, FRAME + 1);
    chk("mid_regrant", bus.grant_o, 4'b0010);
    chk("mid_regrant_din", bus.tx_din_o, wdata[1]);
    bus.req_valid_i = '0;

    // no tx_done_tick from here on
`ifdef UART_ARB_TIMEOUT_EN
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.timeout_o !== 1'b1 && k < 1000);
    chk("timeout_latency", k, TMO);
    chk("timeout_grant", bus.grant_o, 4'b0000);
    @(negedge clk);
    chk("timeout_pulse_len", bus.timeout_o, 1'b0);
    chk("timeout_flush_busy", bus.busy_o, 1'b1);
`else
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (bus.busy_o !== 1'b1 || bus.timeout_o !== 1'b0 || bus.grant_o !== 4'b0010) bad++;
    end
    chk("no_timeout_hold", bad, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
